pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the payload width in bits (legal range 1..128).
REQ-002 The block SHALL have parameter BUBBLE_V, default 0, meaning the payload value presented and loaded on reset, bubble and empty.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  freezes the stage: no transfer in either direction; contents held.
REQ-006 bubble  in  1  flushes the stage: all entries discarded at the next edge.
REQ-007 in_valid  in  1  upstream payload valid.
REQ-008 in_data  in  WIDTH  upstream payload.
REQ-009 in_ready  out  1  stage can accept in_data this cycle.
REQ-010 out_valid  out  1  out_data holds a live entry.
REQ-011 out_data  out  WIDTH  head entry, or BUBBLE_V when empty.
REQ-012 out_ready  in  1  downstream accepts out_data this cycle.
REQ-013 occupancy  out  2  number of live entries, 0..2.

Function
REQ-014 Storage SHALL be two entries, head and skid, plus a state register with states EMPTY (0 entries), HALF (1) and FULL (2).
REQ-015 Push SHALL be defined as in_valid & in_ready, and pop as out_valid & out_ready.
REQ-016 in_ready SHALL equal ~stall & ~bubble & (state != FULL).
REQ-017 out_valid SHALL equal ~stall & ~bubble & (state != EMPTY).
REQ-018 out_data SHALL equal head when state != EMPTY, and BUBBLE_V otherwise.
REQ-019 On EMPTY with push: head <= in_data, next state HALF.
REQ-020 On HALF with push and no pop: skid <= in_data, next state FULL.
REQ-021 On HALF with push and pop: head <= in_data, state remains HALF.
REQ-022 On HALF with pop and no push: head <= BUBBLE_V, next state EMPTY.
REQ-023 On FULL with pop: head <= skid, skid <= BUBBLE_V, next state HALF; push is impossible in FULL.
REQ-024 With no push and no pop, state, head and skid SHALL hold.
REQ-025 bubble=1 SHALL take priority over stall and all handshakes: state <= EMPTY, head <= BUBBLE_V, skid <= BUBBLE_V; a concurrent in_valid is dropped.
REQ-026 With stall=1 and bubble=0, all registers SHALL hold regardless of in_valid and out_ready.
REQ-027 Latency: a payload pushed at edge N SHALL appear on out_data with out_valid=1 in the cycle after edge N, provided the stage was EMPTY, or HALF with a concurrent pop.
REQ-028 Zero-bubble throughput: with in_valid=1 and out_ready=1 held continuously, the stage SHALL sustain one transfer per cycle in HALF.
REQ-029 Payload order SHALL be strictly FIFO; no entry is lost or duplicated except by bubble.
REQ-030 occupancy SHALL encode EMPTY=0, HALF=1, FULL=2; value 3 is never driven.

Reset
REQ-031 While resetn=0: state=EMPTY, head=skid=BUBBLE_V, out_valid=0, occupancy=0, out_data=BUBBLE_V; in_ready=1 when stall=bubble=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-033 The first push SHALL be accepted at the first rising edge after resetn deasserts.

Structure
REQ-034 The state encoding (EMPTY/HALF/FULL) SHALL live in shared package pipe_pkg, for reuse by all stage registers.
REQ-035 No sub-module is required; head and skid are plain registers, with all next-state logic in one block.
REQ-036 The block SHALL be a drop-in replacement for single-field stage registers: stall=bubble=0 with out_ready=1 reduces it to a one-cycle register.

Verification (WIDTH=8, BUBBLE_V=8'hFF)
REQ-037 Reset then idle -> out_data=FF, out_valid=0, occupancy=0, in_ready=1.
REQ-038 Stream 01,02,03 with out_ready=1 -> out_data shows 01,02,03 on consecutive cycles, each one cycle after its push; occupancy stays 1.
REQ-039 out_ready=0 while pushing 10,11,12 -> 10 and 11 accepted, in_ready=0 at FULL, 12 held upstream; then out_ready=1 -> outputs 10,11,12 in order.
REQ-040 FULL(20,21) with stall=1 for 3 cycles and out_ready=1 -> no pop, out_valid=0, contents held; after release, outputs 20 then 21.
REQ-041 FULL(30,31) with bubble=1 and stall=1 simultaneously -> next cycle EMPTY, out_data=FF, both entries gone.
REQ-042 resetn pulsed low mid-stream at HALF(40) -> out_valid drops immediately and out_data=FF; after release, a push of 41 emerges next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy state encoding
// and a helper that maps it onto the numeric occupancy count.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  localparam int unsigned MAX_ENTRIES = 2;

  function automatic logic [1:0] occ_of(input pipe_state_e st);
    case (st)
      ST_HALF: occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage with stall (freeze) and bubble (flush) controls.
// Drop-in for a plain stage register: with stall=bubble=0 and out_ready=1 it is one cycle deep.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] BUBBLE_V = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             stall,
  input  logic             bubble,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output pipe_state_e      state_dbg
);

  // Handshake: a transfer happens on an edge where valid and ready are both 1
  // on that side; neither ready nor valid is asserted while stalled or flushed.
  pipe_state_e      state;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic             push;
  logic             pop;

  assign in_ready  = ~stall & ~bubble & (state != ST_FULL);
  assign out_valid = ~stall & ~bubble & (state != ST_EMPTY);
  assign out_data  = (state != ST_EMPTY) ? head : BUBBLE_V;
  assign occupancy = occ_of(state);
  assign state_dbg = state;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_EMPTY;
      head  <= BUBBLE_V;
      skid  <= BUBBLE_V;
    end else if (bubble) begin
      // Flush wins over stall and any handshake; concurrent input is dropped.
      state <= ST_EMPTY;
      head  <= BUBBLE_V;
      skid  <= BUBBLE_V;
    end else if (!stall) begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head  <= in_data;
            state <= ST_HALF;
          end
        end
        ST_HALF: begin
          if (push && !pop) begin
            skid  <= in_data;
            state <= ST_FULL;
          end else if (push && pop) begin
            head <= in_data;
          end else if (pop) begin
            head  <= BUBBLE_V;
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can occur.
          if (pop) begin
            head  <= skid;
            skid  <= BUBBLE_V;
            state <= ST_HALF;
          end
        end
        default: begin
          state <= ST_EMPTY;
          head  <= BUBBLE_V;
          skid  <= BUBBLE_V;
        end
      endcase
    end
  end

endmodule
